ps2_host_tx: RTL and testbench

- Host-to-device PS/2 transmitter, the opposite direction of the existing keyboard receiver path.
- Sends one command byte to the keyboard, e.g. 0xFF reset, 0xED set-LEDs, 0xF4 enable.
- Sits beside the receiver on the shared ps2c/ps2d inout pins. It drives both lines open-drain during a transmission and releases them otherwise, so the receiver sees the bus idle.
- Reports completion, or an error (missing ACK or timeout), to the game control logic.

---
 rtl/ps2_pkg.sv | 34 +++
 rtl/ps2_host_tx_if.sv | 30 +++
 rtl/ps2_clk_filter.sv | 44 ++++
 rtl/ps2_host_tx.sv | 173 +++++++++++++++++
 tb/tb_ps2_host_tx.sv | 279 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/ps2_pkg.sv
// ps2_pkg: definitions shared by the PS/2 host transmitter and the keyboard
// receiver path. Holds the transmitter FSM encoding, frame constants, the
// shared counter width, common keyboard command bytes and a parity helper.
package ps2_pkg;

    // Shared RTS / timeout counter width; must cover the larger of
    // INHIBIT_CYCLES and TIMEOUT_CYCLES.
    localparam int unsigned CNT_W = 20;

    // Device clock falls in one host-to-device frame: 8 data bits, parity,
    // stop release, and the ACK clock.
    localparam int unsigned PS2_FRAME_FALLS = 11;

    localparam logic [7:0] CMD_RESET   = 8'hFF;
    localparam logic [7:0] CMD_SET_LED = 8'hED;
    localparam logic [7:0] CMD_ENABLE  = 8'hF4;
    localparam logic [7:0] RSP_ACK     = 8'hFA;

    typedef enum logic [2:0] {
        IDLE,
        RTS,
        SEND,
        ACK,
        WAIT_IDLE,
        DONE,
        ERR
    } ps2_tx_state_t;

    // Odd parity bit: set when the byte holds an even number of ones.
    function automatic logic odd_parity(input logic [7:0] b);
        return ~^b;
    endfunction

endpackage

// File: rtl/ps2_host_tx_if.sv
// ps2_host_tx_if: command handshake between the game control logic and the
// PS/2 host transmitter.
//   wr_ps2       : single-cycle start strobe (controller -> transmitter)
//   din          : command byte, taken with an accepted wr_ps2
//   tx_idle      : transmitter is idle and can accept a command
//   tx_done_tick : one-cycle pulse, byte sent and acknowledged
//   tx_error     : one-cycle pulse, transfer aborted (no ACK or timeout)
interface ps2_host_tx_if;
    logic       wr_ps2;
    logic [7:0] din;
    logic       tx_idle;
    logic       tx_done_tick;
    logic       tx_error;

    modport master (
        output wr_ps2,
        output din,
        input  tx_idle,
        input  tx_done_tick,
        input  tx_error
    );

    modport slave (
        input  wr_ps2,
        input  din,
        output tx_idle,
        output tx_done_tick,
        output tx_error
    );
endinterface

// File: rtl/ps2_clk_filter.sv
// ps2_clk_filter: debounces the raw PS/2 clock line and flags its falling
// edges. Shared by the host transmitter and the keyboard receiver.
//   clk      : system clock
//   reset_n  : asynchronous active-low reset
//   ps2c_in  : raw PS/2 clock line
//   f_ps2c   : filtered clock; changes only after FILTER_LEN equal samples
//   fall     : one-cycle flag, filtered clock going from 1 to 0
module ps2_clk_filter #(
    parameter int unsigned FILTER_LEN = 8
) (
    input  logic clk,
    input  logic reset_n,
    input  logic ps2c_in,
    output logic f_ps2c,
    output logic fall
);

    logic [FILTER_LEN-1:0] sr_q;
    logic                  f_q;
    logic                  f_d;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sr_q <= '0;
            f_q  <= 1'b0;
        end else begin
            sr_q <= {ps2c_in, sr_q[FILTER_LEN-1:1]};
            f_q  <= f_d;
        end
    end

    always_comb begin
        f_d = f_q;
        if (&sr_q) begin
            f_d = 1'b1;
        end else if (~|sr_q) begin
            f_d = 1'b0;
        end
    end

    assign f_ps2c = f_q;
    assign fall   = f_q & ~f_d;

endmodule

// File: rtl/ps2_host_tx.sv
// ps2_host_tx: host-to-device PS/2 transmitter. Sends one command byte to the
// keyboard using open-drain drive on the shared ps2c/ps2d pins, releasing
// both lines whenever no transfer is in progress.
//   clk      : system clock (50 MHz)
//   reset_n  : asynchronous active-low reset
//   bus      : command handshake (wr_ps2, din, tx_idle, tx_done_tick, tx_error)
//   ps2c     : PS/2 clock, driven 0 or released (external pull-up)
//   ps2d     : PS/2 data, driven 0 or released (external pull-up)
module ps2_host_tx
    import ps2_pkg::*;
#(
    parameter int unsigned INHIBIT_CYCLES = 6000,
    parameter int unsigned TIMEOUT_CYCLES = 1_000_000,
    parameter int unsigned FILTER_LEN     = 8
) (
    input  logic           clk,
    input  logic           reset_n,
    ps2_host_tx_if.slave   bus,
    inout  wire            ps2c,
    inout  wire            ps2d
);

    localparam logic [CNT_W-1:0] INHIBIT_LAST = CNT_W'(INHIBIT_CYCLES - 1);
    localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
    // The fall that releases the data line for the stop bit.
    localparam logic [3:0]       STOP_FALL    = 4'(PS2_FRAME_FALLS - 1);

    ps2_tx_state_t    state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [3:0]       edge_q, edge_d;
    logic [3:0]       edge_next;
    logic [8:0]       shreg_q, shreg_d;
    logic             c_en_q, c_en_d;
    logic             d_en_q, d_en_d;

    logic             f_ps2c;
    logic             fall;

    // Falls are consumed only while the host has released ps2c, so the
    // filter seeing the host's own RTS pull-down is harmless.
    ps2_clk_filter #(
        .FILTER_LEN (FILTER_LEN)
    ) u_clk_filter (
        .clk     (clk),
        .reset_n (reset_n),
        .ps2c_in (ps2c),
        .f_ps2c  (f_ps2c),
        .fall    (fall)
    );

    assign ps2c = c_en_q ? 1'b0 : 1'bz;
    assign ps2d = d_en_q ? 1'b0 : 1'bz;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            edge_q  <= '0;
            shreg_q <= '0;
            c_en_q  <= 1'b0;
            d_en_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            edge_q  <= edge_d;
            shreg_q <= shreg_d;
            c_en_q  <= c_en_d;
            d_en_q  <= d_en_d;
        end
    end

    always_comb begin
        state_d          = state_q;
        cnt_d            = cnt_q;
        edge_d           = edge_q;
        shreg_d          = shreg_q;
        c_en_d           = c_en_q;
        d_en_d           = d_en_q;
        edge_next        = edge_q + 4'd1;
        bus.tx_idle      = 1'b0;
        bus.tx_done_tick = 1'b0;
        bus.tx_error     = 1'b0;

        case (state_q)
            IDLE: begin
                bus.tx_idle = 1'b1;
                if (bus.wr_ps2) begin
                    shreg_d = {odd_parity(bus.din), bus.din};
                    c_en_d  = 1'b1;
                    cnt_d   = '0;
                    state_d = RTS;
                end
            end

            RTS: begin
                if (cnt_q == INHIBIT_LAST) begin
                    // Start bit goes out as ps2c is released.
                    c_en_d  = 1'b0;
                    d_en_d  = 1'b1;
                    edge_d  = '0;
                    cnt_d   = '0;
                    state_d = SEND;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end

            SEND: begin
                if (fall) begin
                    cnt_d  = '0;
                    edge_d = edge_next;
                    if (edge_next == STOP_FALL) begin
                        d_en_d  = 1'b0;
                        state_d = ACK;
                    end else begin
                        d_en_d  = ~shreg_q[0];
                        shreg_d = {1'b0, shreg_q[8:1]};
                    end
                end else if (cnt_q == TIMEOUT_LAST) begin
                    c_en_d  = 1'b0;
                    d_en_d  = 1'b0;
                    cnt_d   = '0;
                    state_d = ERR;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end

            ACK: begin
                if (fall) begin
                    cnt_d   = '0;
                    edge_d  = edge_next;
                    state_d = (ps2d == 1'b0) ? WAIT_IDLE : ERR;
                end else if (cnt_q == TIMEOUT_LAST) begin
                    cnt_d   = '0;
                    state_d = ERR;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end

            WAIT_IDLE: begin
                if (f_ps2c && (ps2d == 1'b1)) begin
                    state_d = DONE;
                end else if (cnt_q == TIMEOUT_LAST) begin
                    cnt_d   = '0;
                    state_d = ERR;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end

            DONE: begin
                bus.tx_done_tick = 1'b1;
                state_d          = IDLE;
            end

            ERR: begin
                bus.tx_error = 1'b1;
                c_en_d       = 1'b0;
                d_en_d       = 1'b0;
                state_d      = IDLE;
            end

            default: begin
                c_en_d  = 1'b0;
                d_en_d  = 1'b0;
                state_d = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_ps2_host_tx.sv
module tb_ps2_host_tx;
    import ps2_pkg::*;

    localparam int INH  = 50;
    localparam int TMO  = 2000;
    localparam int HALF = 40;

    logic clk     = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    wire  ps2c;
    wire  ps2d;
    logic dev_c = 1'b0;
    logic dev_d = 1'b0;
    pullup (ps2c);
    pullup (ps2d);
    assign ps2c = dev_c ? 1'b0 : 1'bz;
    assign ps2d = dev_d ? 1'b0 : 1'bz;

    ps2_host_tx_if bus_if ();

    ps2_host_tx #(
        .INHIBIT_CYCLES (INH),
        .TIMEOUT_CYCLES (TMO),
        .FILTER_LEN     (8)
    ) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus_if),
        .ps2c    (ps2c),
        .ps2d    (ps2d)
    );

    int n_cmp = 0;
    int n_bad = 0;
    int done_cnt = 0;
    int err_cnt  = 0;

    always @(negedge clk) begin
        if (bus_if.tx_done_tick === 1'b1) done_cnt <= done_cnt + 1;
        if (bus_if.tx_error === 1'b1)     err_cnt  <= err_cnt + 1;
    end

    // Reference frame as the device should see it: start 0, data LSB first,
    // odd parity, stop 1.
    function automatic logic [10:0] model_frame(input logic [7:0] b);
        logic [10:0] f;
        int ones;
        ones = 0;
        f[0] = 1'b0;
        for (int i = 0; i < 8; i++) begin
            f[i+1] = b[i];
            ones += int'(b[i]);
        end
        f[9]  = (ones % 2 == 0) ? 1'b1 : 1'b0;
        f[10] = 1'b1;
        return f;
    endfunction

    task automatic send_cmd(input logic [7:0] b);
        bus_if.din    = b;
        bus_if.wr_ps2 = 1'b1;
        @(negedge clk);
        bus_if.wr_ps2 = 1'b0;
    endtask

    // Keyboard model. Measures the RTS inhibit, then clocks the frame and
    // samples ps2d at the end of each low phase. Optionally ACKs, injects a
    // busy strobe at fall inj_fall, or asserts reset at fall rst_fall.
    task automatic dev_xfer(input bit do_ack, input int inj_fall, input int rst_fall,
                            output logic [10:0] bits, output int low_len,
                            output bit ok, output logic pre_d);
        int n;
        bits    = '0;
        low_len = 0;
        ok      = 1'b1;
        pre_d   = 1'b1;
        n = 0;
        while (ps2c !== 1'b0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (ps2c !== 1'b0) begin
            ok = 1'b0;
            return;
        end
        while (ps2c === 1'b0 && low_len < 1000) begin
            low_len++;
            @(negedge clk);
        end
        bits[0] = ps2d;
        repeat (20) @(negedge clk);
        for (int k = 1; k <= 11; k++) begin
            if (k == 11 && do_ack) dev_d = 1'b1;
            dev_c = 1'b1;
            if (k == rst_fall) begin
                pre_d   = ps2d;
                reset_n = 1'b0;
                dev_c   = 1'b0;
                dev_d   = 1'b0;
                return;
            end
            if (k == inj_fall) begin
                bus_if.din    = 8'h11;
                bus_if.wr_ps2 = 1'b1;
                @(negedge clk);
                bus_if.wr_ps2 = 1'b0;
                repeat (HALF - 1) @(negedge clk);
            end else begin
                repeat (HALF) @(negedge clk);
            end
            if (k <= 10) bits[k] = ps2d;
            dev_c = 1'b0;
            if (k == 11) dev_d = 1'b0;
            repeat (HALF) @(negedge clk);
        end
    endtask

    task automatic test_reset;
        reset_n       = 1'b0;
        bus_if.wr_ps2 = 1'b0;
        bus_if.din    = 8'h00;
        repeat (3) @(negedge clk);
        n_cmp++; if (bus_if.tx_idle !== 1'b1) begin n_bad++; $display("FAIL reset_idle: got %b want 1", bus_if.tx_idle); end
        n_cmp++; if (bus_if.tx_done_tick !== 1'b0) begin n_bad++; $display("FAIL reset_done: got %b want 0", bus_if.tx_done_tick); end
        n_cmp++; if (bus_if.tx_error !== 1'b0) begin n_bad++; $display("FAIL reset_err: got %b want 0", bus_if.tx_error); end
        n_cmp++; if (ps2c !== 1'b1 || ps2d !== 1'b1) begin n_bad++; $display("FAIL reset_lines: got c=%b d=%b want 1 1", ps2c, ps2d); end
        reset_n = 1'b1;
        repeat (20) @(negedge clk);
    endtask

    task automatic test_basic_send;
        logic [10:0] bits;
        int low, d0, e0;
        bit ok;
        logic pre;
        d0 = done_cnt; e0 = err_cnt;
        send_cmd(CMD_SET_LED);
        dev_xfer(1'b1, 0, 0, bits, low, ok, pre);
        repeat (5) @(negedge clk);
        n_cmp++; if (ok !== 1'b1) begin n_bad++; $display("FAIL basic_rts_seen: got %b want 1", ok); end
        n_cmp++; if (low != INH) begin n_bad++; $display("FAIL basic_inhibit: got %0d want %0d", low, INH); end
        n_cmp++; if (bits[0] !== 1'b0) begin n_bad++; $display("FAIL basic_start: got %b want 0", bits[0]); end
        n_cmp++; if (bits[8:1] !== 8'hED) begin n_bad++; $display("FAIL basic_data: got %h want ed", bits[8:1]); end
        n_cmp++; if (bits[9] !== 1'b1) begin n_bad++; $display("FAIL basic_parity: got %b want 1", bits[9]); end
        n_cmp++; if (bits[10] !== 1'b1) begin n_bad++; $display("FAIL basic_stop: got %b want 1", bits[10]); end
        n_cmp++; if (done_cnt - d0 != 1) begin n_bad++; $display("FAIL basic_done: got %0d want 1", done_cnt - d0); end
        n_cmp++; if (err_cnt - e0 != 0) begin n_bad++; $display("FAIL basic_err: got %0d want 0", err_cnt - e0); end
        n_cmp++; if (bus_if.tx_idle !== 1'b1) begin n_bad++; $display("FAIL basic_idle: got %b want 1", bus_if.tx_idle); end
    endtask

    task automatic test_parity;
        logic [7:0]  bytes [6];
        logic        par_tab [3];
        logic [10:0] bits, exp_f;
        int low, d0, frame_errs;
        bit ok;
        logic pre;
        bytes[0] = 8'h00; bytes[1] = 8'h01; bytes[2] = 8'hFF;
        par_tab[0] = 1'b1; par_tab[1] = 1'b0; par_tab[2] = 1'b1;
        for (int i = 3; i < 6; i++) bytes[i] = 8'($urandom);
        frame_errs = 0;
        for (int i = 0; i < 6; i++) begin
            d0 = done_cnt;
            send_cmd(bytes[i]);
            dev_xfer(1'b1, 0, 0, bits, low, ok, pre);
            repeat (5) @(negedge clk);
            exp_f = model_frame(bytes[i]);
            if (i < 3) begin
                n_cmp++; if (bits[9] !== par_tab[i]) begin n_bad++; $display("FAIL parity_%0h: got %b want %b", bytes[i], bits[9], par_tab[i]); end
            end
            if (bits !== exp_f || low != INH || !ok) frame_errs++;
            n_cmp++; if (done_cnt - d0 != 1) begin n_bad++; $display("FAIL parity_done_%0h: got %0d want 1", bytes[i], done_cnt - d0); end
        end
        n_cmp++; if (frame_errs != 0) begin n_bad++; $display("FAIL parity_frames: got %0d bad frames want 0", frame_errs); end
    endtask

    task automatic test_missing_ack;
        logic [10:0] bits;
        logic [7:0] b;
        int low, d0, e0;
        bit ok;
        logic pre;
        b = 8'($urandom);
        d0 = done_cnt; e0 = err_cnt;
        send_cmd(b);
        dev_xfer(1'b0, 0, 0, bits, low, ok, pre);
        repeat (5) @(negedge clk);
        n_cmp++; if (bits !== model_frame(b)) begin n_bad++; $display("FAIL nack_frame: got %h want %h", bits, model_frame(b)); end
        n_cmp++; if (err_cnt - e0 != 1) begin n_bad++; $display("FAIL nack_err: got %0d want 1", err_cnt - e0); end
        n_cmp++; if (done_cnt - d0 != 0) begin n_bad++; $display("FAIL nack_done: got %0d want 0", done_cnt - d0); end
        n_cmp++; if (ps2c !== 1'b1 || ps2d !== 1'b1) begin n_bad++; $display("FAIL nack_lines: got c=%b d=%b want 1 1", ps2c, ps2d); end
        n_cmp++; if (bus_if.tx_idle !== 1'b1) begin n_bad++; $display("FAIL nack_idle: got %b want 1", bus_if.tx_idle); end
    endtask

    task automatic test_timeout;
        int n, e0, d0;
        e0 = err_cnt; d0 = done_cnt;
        send_cmd(CMD_ENABLE);
        n = 0;
        while (ps2c !== 1'b0 && n < 200) begin @(negedge clk); n++; end
        n = 0;
        while (ps2c === 1'b0 && n < 1000) begin @(negedge clk); n++; end
        n = 0;
        while (bus_if.tx_error !== 1'b1 && n < 3000) begin @(negedge clk); n++; end
        n_cmp++; if (n != TMO) begin n_bad++; $display("FAIL timeout_cycles: got %0d want %0d", n, TMO); end
        repeat (3) @(negedge clk);
        n_cmp++; if (err_cnt - e0 != 1) begin n_bad++; $display("FAIL timeout_err: got %0d want 1", err_cnt - e0); end
        n_cmp++; if (done_cnt - d0 != 0) begin n_bad++; $display("FAIL timeout_done: got %0d want 0", done_cnt - d0); end
        n_cmp++; if (bus_if.tx_idle !== 1'b1 || ps2d !== 1'b1) begin n_bad++; $display("FAIL timeout_idle: got idle=%b d=%b want 1 1", bus_if.tx_idle, ps2d); end
    endtask

    task automatic test_busy;
        logic [10:0] bits;
        logic [7:0] b;
        int low, d0;
        bit ok;
        logic pre;
        b = 8'($urandom);
        if (b == 8'h11) b = 8'h5A;
        d0 = done_cnt;
        send_cmd(b);
        dev_xfer(1'b1, 3, 0, bits, low, ok, pre);
        repeat (5) @(negedge clk);
        n_cmp++; if (bits !== model_frame(b)) begin n_bad++; $display("FAIL busy_frame: got %h want %h", bits, model_frame(b)); end
        n_cmp++; if (done_cnt - d0 != 1) begin n_bad++; $display("FAIL busy_done: got %0d want 1", done_cnt - d0); end
        // The ignored strobe must not start a second transfer.
        repeat (100) @(negedge clk);
        n_cmp++; if (bus_if.tx_idle !== 1'b1 || ps2c !== 1'b1) begin n_bad++; $display("FAIL busy_no_restart: got idle=%b c=%b want 1 1", bus_if.tx_idle, ps2c); end
    endtask

    task automatic test_reset_mid;
        logic [10:0] bits, exp_f;
        logic [7:0] b;
        int low, d0, e0;
        bit ok;
        logic pre;
        b = 8'($urandom) & 8'hF7;
        exp_f = model_frame(b);
        d0 = done_cnt; e0 = err_cnt;
        send_cmd(b);
        dev_xfer(1'b1, 0, 5, bits, low, ok, pre);
        n_cmp++; if (pre !== exp_f[4]) begin n_bad++; $display("FAIL rst_pre_d: got %b want %b", pre, exp_f[4]); end
        #1;
        n_cmp++; if (ps2c !== 1'b1 || ps2d !== 1'b1) begin n_bad++; $display("FAIL rst_release: got c=%b d=%b want 1 1", ps2c, ps2d); end
        n_cmp++; if (bus_if.tx_idle !== 1'b1) begin n_bad++; $display("FAIL rst_idle: got %b want 1", bus_if.tx_idle); end
        @(negedge clk);
        repeat (5) @(negedge clk);
        reset_n = 1'b1;
        repeat (30) @(negedge clk);
        n_cmp++; if (done_cnt != d0 || err_cnt != e0) begin n_bad++; $display("FAIL rst_pulses: got done=%0d err=%0d want 0 0", done_cnt - d0, err_cnt - e0); end
        b = 8'($urandom);
        d0 = done_cnt;
        send_cmd(b);
        dev_xfer(1'b1, 0, 0, bits, low, ok, pre);
        repeat (5) @(negedge clk);
        n_cmp++; if (bits !== model_frame(b) || done_cnt - d0 != 1) begin n_bad++; $display("FAIL rst_recover: got %h done=%0d want %h done=1", bits, done_cnt - d0, model_frame(b)); end
    endtask

    initial begin
        #3_000_000;
        $display("FAIL watchdog: got no finish want finish before time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin
        test_reset();
        test_basic_send();
        test_parity();
        test_missing_ack();
        test_timeout();
        test_busy();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
